// File: rtl/memory_access_stage.sv
// memory_access_stage: RV32I memory stage bridging load/store requests to a req/ack data-memory port.
//   Ports: clk, rst_n (async active-low); MemReadM, MemWriteM, Funct3M, ALUResultM, WriteDataM from EX/MEM;
//   DataMemoryOutM, StallM, MisalignM, BusErrorM to the pipeline; mem_req/we/addr/wdata/be, mem_ack/rdata to memory.
module memory_access_stage #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] DataMemoryOutM,
   output logic        StallM,
   output logic        MisalignM,
   output logic        BusErrorM,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);
   state_t      state_q;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] addr_q, wdata_q, dout_q, wdata_d, sh, ld_fmt;
   logic [3:0]  be_q, be_d;
   logic        we_q, berr_q, access, start, is_b, is_h, is_w, timeout;
   // Funct3 low bits 00 = byte, 01 = half; any other code behaves as a word
   assign is_b      = Funct3M[1:0] == 2'b00;
   assign is_h      = Funct3M[1:0] == 2'b01;
   assign is_w      = Funct3M[1];
   assign access    = MemReadM | MemWriteM;
   assign MisalignM = access & (is_w ? |ALUResultM[1:0] : is_h & ALUResultM[0]);
   assign start     = access & ~MisalignM;
   assign StallM    = rst_n & ((state_q == IDLE & start) | state_q == BUSY);
   assign mem_req   = state_q == BUSY;
   assign cnt_d     = cnt_q + 8'd1;
   assign timeout   = TO != 8'd0 && cnt_d == TO;
   assign be_d      = ~MemWriteM ? 4'hF : is_b ? 4'b0001 << ALUResultM[1:0] :
                      is_h ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'hF;
   assign wdata_d   = ~MemWriteM ? 32'd0 : is_b ? {4{WriteDataM[7:0]}} :
                      is_h ? {2{WriteDataM[15:0]}} : WriteDataM;
   // Shift the addressed lane down to bit 0, then extend per the latched funct3 (bit 2 = unsigned)
   assign sh        = mem_rdata >> {off_q, 3'b000};
   assign ld_fmt    = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                      f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : mem_rdata;
   assign DataMemoryOutM = dout_q;
   assign BusErrorM = berr_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         off_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         dout_q  <= '0;
         be_q    <= '0;
         we_q    <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               addr_q  <= {ALUResultM[31:2], 2'b00};
               off_q   <= ALUResultM[1:0];
               f3_q    <= Funct3M;
               we_q    <= MemWriteM;
               be_q    <= be_d;
               wdata_q <= wdata_d;
               cnt_q   <= '0;
               state_q <= BUSY;
            end
            BUSY: begin
               cnt_q <= cnt_d;
               // An ack arriving on the timeout cycle still completes normally
               if (mem_ack) begin
                  dout_q  <= we_q ? 32'd0 : ld_fmt;
                  state_q <= DONE;
               end else if (timeout) begin
                  dout_q  <= 32'd0;
                  berr_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               berr_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: randomized scoreboard bench for memory_access_stage with a spec-level reference model.
module tb_memory_access_stage;
   localparam int T = 4;
   logic        clk = 0, rst_n = 0, MemReadM = 0, MemWriteM = 0, mem_ack = 0;
   logic [2:0]  Funct3M = 0;
   logic [31:0] ALUResultM = 0, WriteDataM = 0, mem_rdata = 0;
   logic [31:0] DataMemoryOutM, mem_addr, mem_wdata;
   logic        StallM, MisalignM, BusErrorM, mem_req, mem_we;
   logic [3:0]  mem_be;
   typedef struct {
      logic [31:0] addr, wdata, dout;
      logic [3:0]  be;
      logic        we, berr;
      int          ncyc;
   } exp_t;
   exp_t q[$];
   int   n_vec = 0, n_bad = 0;
   logic abort_ok = 0;

   memory_access_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .DataMemoryOutM(DataMemoryOutM), .StallM(StallM),
      .MisalignM(MisalignM), .BusErrorM(BusErrorM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic misaligned(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
      if (!(rd | wr)) return 0;
      case (f3)
         3'd0, 3'd4: return 0;
         3'd1, 3'd5: return a[0];
         default:    return a[1:0] != 2'b00;
      endcase
   endfunction

   // Expected response straight from the lane/extension rules; d >= T means memory never acks
   function automatic exp_t model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input int d, input logic [31:0] rdat);
      exp_t e;
      logic [31:0] s;
      int off;
      off = int'(a[1:0]);
      e.addr = a & 32'hFFFF_FFFC;
      e.we = wr;
      e.be = 4'hF;
      e.wdata = 0;
      if (wr) begin
         if (f3 == 3'd0 || f3 == 3'd4) begin
            e.be = 4'(1 << off);
            e.wdata = {4{wd[7:0]}};
         end else if (f3 == 3'd1 || f3 == 3'd5) begin
            e.be = off >= 2 ? 4'b1100 : 4'b0011;
            e.wdata = {2{wd[15:0]}};
         end else e.wdata = wd;
      end
      s = rdat >> (8 * off);
      if (d >= T) begin
         e.dout = 0; e.berr = 1; e.ncyc = T;
      end else begin
         e.berr = 0; e.ncyc = d + 1;
         case (f3)
            3'd0: e.dout = 32'($signed(s[7:0]));
            3'd4: e.dout = 32'(s[7:0]);
            3'd1: e.dout = 32'($signed(s[15:0]));
            3'd5: e.dout = 32'(s[15:0]);
            default: e.dout = rdat;
         endcase
         if (wr) e.dout = 0;
      end
      return e;
   endfunction

   // Monitor: pairs each completed access (req falling) with the oldest expected response
   initial begin
      logic prev, c_we;
      logic [31:0] hold, c_addr, c_wdata;
      logic [3:0] c_be;
      int ncyc;
      exp_t e;
      prev = 0; hold = 0; ncyc = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
      forever begin
         @(posedge clk);
         #2;
         if (!rst_n) begin
            prev = 0; hold = 0; ncyc = 0;
         end else begin
            if (mem_req && !prev) begin
               if (!abort_ok) chk("req_has_txn", 32'(q.size() != 0), 1);
               c_addr = mem_addr; c_we = mem_we; c_be = mem_be; c_wdata = mem_wdata; ncyc = 0;
            end
            if (mem_req) ncyc++;
            if (prev && !mem_req) begin
               chk("done_has_txn", 32'(q.size() != 0), 1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk("dout", DataMemoryOutM, e.dout);
                  chk("bus_error", 32'(BusErrorM), 32'(e.berr));
                  chk("mem_addr", c_addr, e.addr);
                  chk("mem_we", 32'(c_we), 32'(e.we));
                  chk("mem_be", 32'(c_be), 32'(e.be));
                  chk("mem_wdata", c_wdata, e.wdata);
                  chk("req_cycles", 32'(ncyc), 32'(e.ncyc));
                  chk("stall_done", 32'(StallM), 0);
                  hold = e.dout;
               end
            end else begin
               chk("dout_hold", DataMemoryOutM, hold);
               chk("berr_clear", 32'(BusErrorM), 0);
            end
            prev = mem_req;
         end
      end
   end

   task automatic run(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int d, input logic [31:0] rdat);
      logic mis, done;
      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
      mis = misaligned(rd, wr, f3, a);
      #1;
      chk("misalign", 32'(MisalignM), 32'(mis));
      if (!(rd | wr) || mis) begin
         chk("stall_noaccess", 32'(StallM), 0);
         @(negedge clk);
         chk("no_req", 32'(mem_req), 0);
         MemReadM = 0; MemWriteM = 0;
         return;
      end
      q.push_back(model(wr, f3, a, wd, d, rdat));
      chk("stall_start", 32'(StallM), 1);
      @(negedge clk);
      done = 0;
      for (int k = 0; k < 8 && !done; k++) begin
         mem_ack = (k == d);
         mem_rdata = (k == d) ? rdat : $urandom;
         @(negedge clk);
         mem_ack = 0;
         #1;
         if (!StallM) done = 1;
      end
      chk("access_finished", 32'(done), 1);
      // A stray ack while the stage is finishing must be ignored
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      MemReadM = 0; MemWriteM = 0;
      @(negedge clk);
      mem_ack = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int op;
      MemReadM = 1; Funct3M = 3'd2; ALUResultM = 32'h100;
      #12;
      chk("rst_stall", 32'(StallM), 0);
      chk("rst_req", 32'(mem_req), 0);
      chk("rst_dout", DataMemoryOutM, 0);
      chk("rst_berr", 32'(BusErrorM), 0);
      chk("rst_be", 32'(mem_be), 0);
      chk("rst_addr", mem_addr, 0);
      MemReadM = 0;
      @(negedge clk);
      rst_n = 1;
      run(1, 0, 3'd2, 32'h100, 0, 0, 32'hDEADBEEF);
      run(1, 0, 3'd0, 32'h103, 0, 0, 32'h80FF1234);
      run(1, 0, 3'd4, 32'h103, 0, 1, 32'h80FF1234);
      run(1, 0, 3'd1, 32'h102, 0, 2, 32'h80FF1234);
      run(1, 0, 3'd5, 32'h102, 0, 0, 32'h80FF1234);
      run(0, 1, 3'd0, 32'h201, 32'hAB, 0, 32'h12345678);
      run(1, 0, 3'd2, 32'h102, 0, 0, 0);
      run(0, 1, 3'd1, 32'h203, 32'h5555, 0, 0);
      run(1, 0, 3'd2, 32'h400, 0, 99, 32'hCAFEF00D);
      run(1, 0, 3'd2, 32'h404, 0, T - 1, 32'h0BADF00D);
      run(1, 1, 3'd1, 32'h302, 32'h1234ABCD, 1, 32'hFFFFFFFF);
      // Reset during the second BUSY cycle drops the access; a late ack must be ignored
      abort_ok = 1;
      @(negedge clk);
      MemReadM = 1; Funct3M = 3'd2; ALUResultM = 32'h500;
      @(negedge clk);
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("abort_req", 32'(mem_req), 0);
      chk("abort_stall", 32'(StallM), 0);
      chk("abort_dout", DataMemoryOutM, 0);
      @(negedge clk);
      MemReadM = 0;
      rst_n = 1;
      @(negedge clk);
      mem_ack = 1; mem_rdata = 32'h13579BDF;
      @(negedge clk);
      mem_ack = 0;
      #1;
      chk("late_ack_dout", DataMemoryOutM, 0);
      chk("late_ack_req", 32'(mem_req), 0);
      @(negedge clk);
      abort_ok = 0;
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         op = $urandom_range(0, 7);
         run(op inside {[1:3]} || op == 7, op inside {[4:6]} || op == 7, 3'($urandom_range(0, 7)), a,
             $urandom, $urandom_range(0, T + 1), $urandom);
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
